// File: rtl/time_tmr_arbiter.sv
// Round-robin arbiter and credit scheduler in front of a time-redundant datapath.
// Optional credit watchdog: define TIME_TMR_ARB_WATCHDOG_EN.
module time_tmr_arbiter #(
    parameter int NumReq         = 4,
    parameter int DataWidth      = 8,
    parameter int MaxOutstanding = 4,
    parameter int WatchdogCycles = 64,
    parameter int TagW           = $clog2(NumReq),
    parameter int CntW           = $clog2(MaxOutstanding + 1)
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [NumReq-1:0][DataWidth-1:0]   req_data_i,
    input  logic [NumReq-1:0]                  req_valid_i,
    output logic [NumReq-1:0]                  req_ready_o,
    output logic [DataWidth-1:0]               data_o,
    output logic [TagW-1:0]                    tag_o,
    output logic                               valid_o,
    input  logic                               ready_i,
    input  logic [DataWidth-1:0]               done_data_i,
    input  logic [TagW-1:0]                    done_tag_i,
    input  logic                               done_valid_i,
    output logic                               done_ready_o,
    output logic [DataWidth-1:0]               resp_data_o,
    output logic [NumReq-1:0]                  resp_valid_o,
    input  logic [NumReq-1:0]                  resp_ready_i,
    output logic [CntW-1:0]                    credits_o,
    output logic                               timeout_o
);

    typedef enum logic {IDLE, HOLD} state_e;

    state_e          state_q;
    logic [TagW-1:0] grant_q;
    logic [TagW-1:0] rr_ptr_q;
    logic [TagW-1:0] rr_ptr_d;
    logic [TagW-1:0] grant;
    logic            found;
    logic [CntW-1:0] credits_q;
    logic [CntW-1:0] credits_d;
    logic            credit_ok;
    logic            issue_hs;
    logic            done_hs;

    // Rotating priority search; a latched HOLD grant overrides it.
    always_comb begin : arb
        int idx;
        idx   = 0;
        found = 1'b0;
        grant = rr_ptr_q;
        for (int i = 0; i < NumReq; i++) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= NumReq) idx = idx - NumReq;
            if (!found && req_valid_i[TagW'(idx)]) begin
                found = 1'b1;
                grant = TagW'(idx);
            end
        end
        if (state_q == HOLD) begin
            found = 1'b1;
            grant = grant_q;
        end
    end

    assign credit_ok = (credits_q != CntW'(MaxOutstanding));
    assign valid_o   = found && credit_ok;
    assign data_o    = req_data_i[grant];
    assign tag_o     = grant;
    assign issue_hs  = valid_o && ready_i;
    assign rr_ptr_d  = (grant == TagW'(NumReq - 1)) ? '0 : grant + TagW'(1);

    always_comb begin
        req_ready_o = '0;
        for (int k = 0; k < NumReq; k++)
            req_ready_o[k] = issue_hs && (grant == TagW'(k));
    end

    // Completion routing; an out-of-range tag is drained without a response.
    always_comb begin
        resp_valid_o = '0;
        done_ready_o = 1'b1;
        for (int k = 0; k < NumReq; k++) begin
            if (done_tag_i == TagW'(k)) begin
                resp_valid_o[k] = done_valid_i;
                done_ready_o    = resp_ready_i[k];
            end
        end
    end

    assign resp_data_o = done_data_i;
    assign done_hs     = done_valid_i && done_ready_o;
    assign credits_o   = credits_q;

    always_comb begin
        credits_d = credits_q;
        if (issue_hs && !done_hs)
            credits_d = credits_q + CntW'(1);
        else if (!issue_hs && done_hs && credits_q != '0)
            credits_d = credits_q - CntW'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (valid_o && !ready_i) begin
                    state_q <= HOLD;
                    grant_q <= grant;
                end
                HOLD: if (issue_hs) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
            if (issue_hs) rr_ptr_q <= rr_ptr_d;
        end
    end

`ifdef TIME_TMR_ARB_WATCHDOG_EN
    localparam int WdW = $clog2(WatchdogCycles + 1);

    logic [WdW-1:0] wd_q;
    logic           timeout_q;
    logic           wd_fire;

    assign wd_fire   = !done_hs && (credits_q != '0) && (wd_q == WdW'(WatchdogCycles - 1));
    assign timeout_o = timeout_q;

    // Recovers credits whose completions were lost; a same-cycle issue still counts.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            credits_q <= '0;
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= wd_fire;
            if (wd_fire) begin
                credits_q <= issue_hs ? CntW'(1) : '0;
                wd_q      <= '0;
            end else begin
                credits_q <= credits_d;
                if (done_hs || credits_q == '0) wd_q <= '0;
                else                            wd_q <= wd_q + WdW'(1);
            end
        end
    end
`else
    logic unused_wd;
    assign unused_wd = ^(32'(WatchdogCycles));
    assign timeout_o = 1'b0;

    always_ff @(posedge clk_i) begin
        if (rst_i) credits_q <= '0;
        else       credits_q <= credits_d;
    end
`endif

endmodule

// File: tb/tb_time_tmr_arbiter.sv
// Directed bench: one default instance (4 req, 4 credits) and one with 5 req, 2 credits.
module tb_time_tmr_arbiter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    logic [3:0][7:0] a_req_data;
    logic [3:0]      a_req_valid, a_req_ready, a_resp_valid, a_resp_ready;
    logic [7:0]      a_data, a_done_data, a_resp_data;
    logic [1:0]      a_tag, a_done_tag;
    logic            a_valid, a_ready, a_done_valid, a_done_ready, a_timeout;
    logic [2:0]      a_credits;

    logic [4:0][7:0] b_req_data;
    logic [4:0]      b_req_valid, b_req_ready, b_resp_valid, b_resp_ready;
    logic [7:0]      b_data, b_done_data, b_resp_data;
    logic [2:0]      b_tag, b_done_tag;
    logic            b_valid, b_ready, b_done_valid, b_done_ready, b_timeout;
    logic [1:0]      b_credits;

    time_tmr_arbiter u_a (
        .clk_i(clk), .rst_i(rst),
        .req_data_i(a_req_data), .req_valid_i(a_req_valid), .req_ready_o(a_req_ready),
        .data_o(a_data), .tag_o(a_tag), .valid_o(a_valid), .ready_i(a_ready),
        .done_data_i(a_done_data), .done_tag_i(a_done_tag), .done_valid_i(a_done_valid),
        .done_ready_o(a_done_ready), .resp_data_o(a_resp_data), .resp_valid_o(a_resp_valid),
        .resp_ready_i(a_resp_ready), .credits_o(a_credits), .timeout_o(a_timeout)
    );

    time_tmr_arbiter #(.NumReq(5), .MaxOutstanding(2)) u_b (
        .clk_i(clk), .rst_i(rst),
        .req_data_i(b_req_data), .req_valid_i(b_req_valid), .req_ready_o(b_req_ready),
        .data_o(b_data), .tag_o(b_tag), .valid_o(b_valid), .ready_i(b_ready),
        .done_data_i(b_done_data), .done_tag_i(b_done_tag), .done_valid_i(b_done_valid),
        .done_ready_o(b_done_ready), .resp_data_o(b_resp_data), .resp_valid_o(b_resp_valid),
        .resp_ready_i(b_resp_ready), .credits_o(b_credits), .timeout_o(b_timeout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        a_req_valid = '0; a_ready = 1'b0; a_done_data = '0; a_done_tag = '0;
        a_done_valid = 1'b0; a_resp_ready = '0;
        b_req_valid = '0; b_ready = 1'b0; b_done_data = '0; b_done_tag = '0;
        b_done_valid = 1'b0; b_resp_ready = '0;
        for (int k = 0; k < 4; k++) a_req_data[k] = 8'(16 + k);
        for (int k = 0; k < 5; k++) b_req_data[k] = 8'(32 + k);
        step(); step();
        chk("rst_valid",   32'(a_valid), 0);
        chk("rst_credits", 32'(a_credits), 0);
        chk("rst_timeout", 32'(a_timeout), 0);
        chk("rst_rdy",     32'(a_req_ready), 0);
        chk("rst_b_cred",  32'(b_credits), 0);
        rst = 1'b0;
        step();

        // Round-robin order with all requesters valid until credits run out
        a_req_valid = 4'hF; a_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_tag",   32'(a_tag), 32'(i));
            chk("rr_cred",  32'(a_credits), 32'(i));
            chk("rr_valid", 32'(a_valid), 1);
            chk("rr_rdy",   32'(a_req_ready), 32'(1 << i));
            chk("rr_data",  32'(a_data), 32'(16 + i));
            step();
        end
        #1;
        chk("full_cred",  32'(a_credits), 4);
        chk("full_valid", 32'(a_valid), 0);
        chk("full_rdy",   32'(a_req_ready), 0);

        // Completion routing with backpressure, then draining the credits
        a_req_valid = '0; a_ready = 1'b0;
        a_done_tag = 2'd3; a_done_data = 8'h3C; a_done_valid = 1'b1; a_resp_ready = 4'b0111;
        repeat (3) begin
            #1;
            chk("cmp_rv",   32'(a_resp_valid), 32'h8);
            chk("cmp_drdy", 32'(a_done_ready), 0);
            chk("cmp_data", 32'(a_resp_data), 32'h3C);
            step();
        end
        chk("cmp_cred_hold", 32'(a_credits), 4);
        a_resp_ready = 4'hF;
        #1;
        chk("cmp_drdy_rel", 32'(a_done_ready), 1);
        step();
        chk("cmp_cred3", 32'(a_credits), 3);
        a_done_tag = 2'd1;
        #1;
        chk("cmp_rv1", 32'(a_resp_valid), 32'h2);
        step(); step(); step();
        chk("cmp_cred0", 32'(a_credits), 0);
        step();
        chk("cmp_sat0", 32'(a_credits), 0);
        a_done_valid = 1'b0;

        // HOLD stability against a competing requester
        a_req_data[2] = 8'hA5; a_req_valid = 4'b0100; a_ready = 1'b0;
        #1;
        chk("hold_valid0", 32'(a_valid), 1);
        chk("hold_rdy0",   32'(a_req_ready), 0);
        step();
        a_req_valid = 4'b0101;
        repeat (5) begin
            #1;
            chk("hold_tag",   32'(a_tag), 2);
            chk("hold_data",  32'(a_data), 32'hA5);
            chk("hold_valid", 32'(a_valid), 1);
            step();
        end
        a_ready = 1'b1;
        #1;
        chk("hold_rdy", 32'(a_req_ready), 32'h4);
        step();
        chk("hold_cred", 32'(a_credits), 1);
        chk("wrap_tag0", 32'(a_tag), 0);
        a_req_valid = 4'b1001;
        #1;
        chk("next_tag3", 32'(a_tag), 3);
        a_ready = 1'b0;
        step();
        a_req_valid = 4'hF;
        #1;
        chk("hold3_tag", 32'(a_tag), 3);

        // Reset while holding a grant
        rst = 1'b1; a_req_valid = '0;
        step();
        rst = 1'b0;
        #1;
        chk("mrst_valid", 32'(a_valid), 0);
        chk("mrst_cred",  32'(a_credits), 0);
        chk("mrst_rdy",   32'(a_req_ready), 0);
        a_req_valid = 4'b1001;
        #1;
        chk("mrst_tag0", 32'(a_tag), 0);

        // Credit boundary with two credits, legal tag 4 and illegal tag 7
        b_resp_ready = 5'h1F; b_req_valid = 5'b00011; b_ready = 1'b1;
        #1;
        chk("b_tag0", 32'(b_tag), 0);
        chk("b_val0", 32'(b_valid), 1);
        step();
        chk("b_tag1", 32'(b_tag), 1);
        chk("b_cred1", 32'(b_credits), 1);
        step();
        chk("b_cred2", 32'(b_credits), 2);
        chk("b_full_valid", 32'(b_valid), 0);
        chk("b_full_rdy",   32'(b_req_ready), 0);
        b_req_valid = 5'b00100; b_done_tag = 3'd1; b_done_valid = 1'b1; b_done_data = 8'h5A;
        #1;
        chk("b_done_valid_blk", 32'(b_valid), 0);
        chk("b_done_rdy",  32'(b_done_ready), 1);
        chk("b_resp_v1",   32'(b_resp_valid), 32'h02);
        chk("b_resp_data", 32'(b_resp_data), 32'h5A);
        step();
        chk("b_cred_freed", 32'(b_credits), 1);
        b_done_valid = 1'b0;
        #1;
        chk("b_reissue_v", 32'(b_valid), 1);
        chk("b_reissue_t", 32'(b_tag), 2);
        step();
        chk("b_cred2b", 32'(b_credits), 2);
        b_req_valid = 5'b01000; b_done_tag = 3'd0; b_done_valid = 1'b1;
        #1;
        chk("b_blk2", 32'(b_valid), 0);
        step();
        chk("b_cred1b", 32'(b_credits), 1);
        b_done_tag = 3'd4;
        #1;
        chk("b_both_v",  32'(b_valid), 1);
        chk("b_both_t",  32'(b_tag), 3);
        chk("b_rv4",     32'(b_resp_valid), 32'h10);
        step();
        chk("b_both_cred", 32'(b_credits), 1);
        b_req_valid = '0; b_done_tag = 3'd7; b_resp_ready = '0;
        #1;
        chk("b_ill_drdy", 32'(b_done_ready), 1);
        chk("b_ill_rv",   32'(b_resp_valid), 0);
        step();
        chk("b_ill_cred", 32'(b_credits), 0);
        b_done_valid = 1'b0;

        // One issue with no completion
        a_req_valid = 4'b0001; a_ready = 1'b1;
        #1;
        chk("wd_issue_t", 32'(a_tag), 0);
        step();
        a_req_valid = '0; a_ready = 1'b0;
        chk("wd_cred1", 32'(a_credits), 1);
`ifdef TIME_TMR_ARB_WATCHDOG_EN
        for (int i = 1; i <= 64; i++) begin
            step();
            if (i == 63) begin
                chk("wd_pre_to",   32'(a_timeout), 0);
                chk("wd_pre_cred", 32'(a_credits), 1);
            end
        end
        chk("wd_to",      32'(a_timeout), 1);
        chk("wd_cred0",   32'(a_credits), 0);
        step();
        chk("wd_to_pulse", 32'(a_timeout), 0);
`else
        repeat (100) step();
        chk("nowd_cred", 32'(a_credits), 1);
        chk("nowd_to",   32'(a_timeout), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
